race_turn_scheduler: RTL and testbench

Turn scheduler for the multi-player dice race. It shares the single color-detection result stream among 2–4 players in round-robin order and gates out stale or low-confidence results. Each accepted roll becomes a move command, delivered over a valid/ready handshake to the board/piece-mover datapath. The block tracks every player's position and declares the winner. It sits between the color result manager and the board mover / board display.

---
 rtl/race_turn_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_race_turn_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_turn_scheduler.sv
// race_turn_scheduler
// Round-robin turn scheduler for the dice race. Shares the colour-detection
// result stream among NUM_PLAYERS players and rejects stale or low-confidence
// results. Each accepted roll becomes a move command on a valid/ready
// handshake. The block tracks every position and declares the winner.
//
// Optional feature: define RTS_TURN_TIMEOUT_EN to skip a player who produces
// no accepted roll within TIMEOUT_CYCLES. Without it, turn_skipped is tied
// low and WAIT_ROLL waits indefinitely.
module race_turn_scheduler #(
  parameter int unsigned NUM_PLAYERS    = 4,
  parameter int unsigned FINISH_POS     = 15,
  parameter logic [15:0] CONF_THRESH    = 16'd1000,
  parameter int unsigned SETTLE_CYCLES  = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_start,
  input  logic        game_abort,
  input  logic        color_result_ready,
  input  logic [1:0]  movement_steps,
  input  logic [15:0] color_confidence,
  output logic        move_valid,
  output logic [1:0]  move_player,
  output logic [3:0]  move_from,
  output logic [1:0]  move_steps,
  input  logic        move_ready,
  output logic [1:0]  active_player,
  output logic [15:0] positions,
  output logic [2:0]  sched_state,
  output logic        winner_valid,
  output logic [1:0]  winner_id,
  output logic        turn_skipped
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [3:0]  FINISH_4     = 4'(FINISH_POS);
  localparam logic [1:0]  LAST_PLAYER  = 2'(NUM_PLAYERS - 1);
  localparam logic [31:0] SETTLE_LOAD  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  // Position advance that saturates at the goal tile. The sum is formed at
  // five bits so 13+3 cannot wrap back to a low tile before the clamp.
  function automatic logic [3:0] sat_advance(input logic [3:0] from,
                                             input logic [1:0] steps);
    logic [4:0] sum;
    sum = {1'b0, from} + {3'b000, steps};
    if (sum >= {1'b0, FINISH_4}) begin
      sat_advance = FINISH_4;
    end else begin
      sat_advance = sum[3:0];
    end
  endfunction

  logic [2:0]  state;
  logic [31:0] settle_cnt;
  logic        roll_ok;
  logic        timeout_hit;
  logic [3:0]  new_pos;
  logic [3:0]  active_slot;

  assign sched_state = state;
  assign active_slot = {active_player, 2'b00};

  // A result counts only if it carries a colour and is confident enough
  always_comb begin
    roll_ok = color_result_ready && (movement_steps != 2'd0) &&
              (color_confidence >= CONF_THRESH);
  end

  // Landing tile for the command currently being committed
  always_comb begin
    new_pos = sat_advance(move_from, move_steps);
  end

`ifdef RTS_TURN_TIMEOUT_EN
  logic [31:0] wait_cnt;

  // Cycles spent in the current WAIT_ROLL visit; zero on the first cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 32'd0;
    end else if (state == S_WAIT && !game_abort && !roll_ok) begin
      wait_cnt <= wait_cnt + 32'd1;
    end else begin
      wait_cnt <= 32'd0;
    end
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == TIMEOUT_LAST);

  // One-cycle skip pulse; an accepted roll on the timeout cycle wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turn_skipped <= 1'b0;
    end else begin
      turn_skipped <= timeout_hit && !roll_ok && !game_abort;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_LAST;
  assign timeout_hit        = 1'b0;
  assign turn_skipped       = 1'b0;
`endif

  // Turn sequencing, move command register, position file and winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      settle_cnt    <= 32'd0;
      active_player <= 2'd0;
      positions     <= 16'd0;
      move_valid    <= 1'b0;
      move_player   <= 2'd0;
      move_from     <= 4'd0;
      move_steps    <= 2'd0;
      winner_valid  <= 1'b0;
      winner_id     <= 2'd0;
    end else if (game_abort && state != S_IDLE) begin
      // Abort outranks every other event, including a pending transfer
      state         <= S_IDLE;
      active_player <= 2'd0;
      positions     <= 16'd0;
      move_valid    <= 1'b0;
      winner_valid  <= 1'b0;
      winner_id     <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (game_start && !game_abort) begin
            positions     <= 16'd0;
            active_player <= 2'd0;
            settle_cnt    <= SETTLE_LOAD;
            state         <= S_ARM;
          end
        end
        S_ARM: begin
          // Results seen here belong to the previous frame and are dropped
          if (settle_cnt == 32'd0) begin
            state <= S_WAIT;
          end else begin
            settle_cnt <= settle_cnt - 32'd1;
          end
        end
        S_WAIT: begin
          if (roll_ok) begin
            move_player <= active_player;
            move_from   <= positions[active_slot +: 4];
            move_steps  <= movement_steps;
            move_valid  <= 1'b1;
            state       <= S_ISSUE;
          end else if (timeout_hit) begin
            state <= S_NEXT;
          end
        end
        S_ISSUE: begin
          if (move_ready) begin
            move_valid <= 1'b0;
            state      <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          positions[active_slot +: 4] <= new_pos;
          if (new_pos == FINISH_4) begin
            winner_id    <= active_player;
            winner_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          active_player <= (active_player == LAST_PLAYER) ? 2'd0
                                                          : active_player + 2'd1;
          settle_cnt    <= SETTLE_LOAD;
          state         <= S_ARM;
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_turn_scheduler.sv
// Self-checking bench for race_turn_scheduler: a behavioural game model is
// compared against the DUT every cycle, with directed literal checks on top.
module tb_race_turn_scheduler;

  localparam int NP     = 3;
  localparam int SETTLE = 4;
  localparam int TMO    = 8;
  localparam int FIN    = 15;
  localparam int CONF   = 1000;
`ifdef RTS_TURN_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        game_start;
  logic        game_abort;
  logic        color_result_ready;
  logic [1:0]  movement_steps;
  logic [15:0] color_confidence;
  logic        move_valid;
  logic [1:0]  move_player;
  logic [3:0]  move_from;
  logic [1:0]  move_steps;
  logic        move_ready;
  logic [1:0]  active_player;
  logic [15:0] positions;
  logic [2:0]  sched_state;
  logic        winner_valid;
  logic [1:0]  winner_id;
  logic        turn_skipped;

  int checks = 0;
  int errors = 0;

  race_turn_scheduler #(
    .NUM_PLAYERS(NP), .FINISH_POS(FIN), .CONF_THRESH(16'd1000),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .game_abort(game_abort),
    .color_result_ready(color_result_ready), .movement_steps(movement_steps),
    .color_confidence(color_confidence), .move_valid(move_valid),
    .move_player(move_player), .move_from(move_from), .move_steps(move_steps),
    .move_ready(move_ready), .active_player(active_player), .positions(positions),
    .sched_state(sched_state), .winner_valid(winner_valid), .winner_id(winner_id),
    .turn_skipped(turn_skipped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  int m_state = 0, m_active = 0, m_age = 0;
  int m_from = 0, m_steps = 0, m_player = 0, m_winner = 0;
  int m_pos [4] = '{0, 0, 0, 0};
  bit m_mv = 0, m_wv = 0, m_skip = 0;

  task automatic model_clear();
    m_state = 0; m_active = 0; m_age = 0; m_mv = 0; m_wv = 0; m_skip = 0;
    m_winner = 0; m_from = 0; m_steps = 0; m_player = 0;
    for (int i = 0; i < 4; i++) m_pos[i] = 0;
  endtask

  task automatic model_step();
    bit good;
    int land;
    m_skip = 0;
    good = color_result_ready && movement_steps != 0 && color_confidence >= CONF;
    if (game_abort && m_state != 0) begin
      m_state = 0; m_mv = 0; m_wv = 0; m_winner = 0; m_active = 0;
      for (int i = 0; i < 4; i++) m_pos[i] = 0;
      return;
    end
    case (m_state)
      0: if (game_start && !game_abort) begin
           for (int i = 0; i < 4; i++) m_pos[i] = 0;
           m_active = 0; m_age = 0; m_state = 1;
         end
      1: if (m_age == SETTLE - 1) begin m_state = 2; m_age = 0; end
         else m_age++;
      2: if (good) begin
           m_from = m_pos[m_active]; m_steps = movement_steps; m_player = m_active;
           m_mv = 1; m_state = 3;
         end else if (TIMEOUT_ON && m_age == TMO - 1) begin
           m_skip = 1; m_state = 5;
         end else m_age++;
      3: if (move_ready) begin m_mv = 0; m_state = 4; end
      4: begin
           land = m_from + m_steps;
           if (land > FIN) land = FIN;
           m_pos[m_active] = land;
           if (land == FIN) begin m_wv = 1; m_winner = m_active; m_state = 6; end
           else m_state = 5;
         end
      5: begin m_active = (m_active + 1) % NP; m_age = 0; m_state = 1; end
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else model_step();
  end

  function automatic logic [15:0] exp_positions();
    logic [15:0] v;
    v = 16'd0;
    for (int i = 0; i < NP; i++) v[4*i +: 4] = 4'(m_pos[i]);
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  int skip_cnt = 0;
  always @(negedge clk) begin
    chk("sched_state", sched_state, m_state);
    chk("move_valid", move_valid, m_mv);
    if (m_mv) begin
      chk("move_player", move_player, m_player);
      chk("move_from", move_from, m_from);
      chk("move_steps", move_steps, m_steps);
    end
    if (m_state != 0) chk("active_player", active_player, m_active);
    chk("positions", positions, exp_positions());
    chk("winner_valid", winner_valid, m_wv);
    chk("winner_id", winner_id, m_winner);
    chk("turn_skipped", turn_skipped, m_skip);
    if (turn_skipped) skip_cnt++;
  end

  // Record what the mover actually receives
  int xfer_cnt = 0;
  int x_player = -1, x_from = -1, x_steps = -1;
  always @(posedge clk) begin
    if (!reset && move_valid && move_ready) begin
      xfer_cnt++;
      x_player = move_player; x_from = move_from; x_steps = move_steps;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while (sched_state != 3'(s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sched_state != 3'(s)) begin
      checks++; errors++;
      $display("FAIL wait_state actual=%0d required=%0d (timeout)", sched_state, s);
    end
  endtask

  task automatic pulse_roll(input int steps, input int conf);
    color_result_ready = 1'b1;
    movement_steps     = 2'(steps);
    color_confidence   = 16'(conf);
    @(negedge clk);
    color_result_ready = 1'b0;
    movement_steps     = 2'd0;
    color_confidence   = 16'd0;
  endtask

  task automatic start_game();
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  task automatic do_turn(input int steps);
    wait_state(2, 64);
    pulse_roll(steps, 2000);
  endtask

  task automatic abort_game();
    game_abort = 1'b1;
    @(negedge clk);
    game_abort = 1'b0;
  endtask

  int turn_tbl [14] = '{1, 1, 3, 1, 1, 3, 1, 1, 3, 1, 1, 2, 1, 1};

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; game_start = 1'b0; game_abort = 1'b0;
    color_result_ready = 1'b0; movement_steps = 2'd0; color_confidence = 16'd0;
    move_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_state", sched_state, 0);
    chk("idle_positions", positions, 0);

    // Start, with a stale result in the first ARM cycle
    start_game();
    chk("arm_entry", sched_state, 1);
    color_result_ready = 1'b1; movement_steps = 2'd3; color_confidence = 16'd2000;
    cyc = 0;
    while (sched_state != 3'd2 && cyc < 20) begin
      @(negedge clk);
      color_result_ready = 1'b0; movement_steps = 2'd0; color_confidence = 16'd0;
      cyc++;
    end
    chk("arm_length", cyc, SETTLE);
    chk("stale_ignored", move_valid, 0);

    // Rejected results, then a roll exactly at threshold with a stalled mover
    pulse_roll(2, 999);
    chk("conf999_state", sched_state, 2);
    pulse_roll(0, 2000);
    chk("steps0_state", sched_state, 2);
    move_ready = 1'b0;
    pulse_roll(2, 1000);
    chk("thresh_accept_valid", move_valid, 1);
    repeat (10) @(negedge clk);
    chk("stall_valid", move_valid, 1);
    chk("stall_from", move_from, 0);
    chk("stall_steps", move_steps, 2);
    chk("stall_xfers", xfer_cnt, 0);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b1;
    chk("single_xfer", xfer_cnt, 1);

    // Rotation through three players until player 0 sits on tile 13
    foreach (turn_tbl[i]) do_turn(turn_tbl[i]);
    wait_state(2, 64);
    chk("rotation_back_to_0", active_player, 0);
    chk("pre_win_positions", positions, 16'h055D);
    pulse_roll(3, 2000);
    wait_state(6, 64);
    chk("xfer_player", x_player, 0);
    chk("xfer_from", x_from, 13);
    chk("xfer_steps", x_steps, 3);
    chk("win_positions", positions, 16'h055F);
    chk("winner_valid_lit", winner_valid, 1);
    chk("winner_id_lit", winner_id, 0);

    // DONE ignores start; abort returns to IDLE
    start_game();
    @(negedge clk);
    chk("done_ignores_start", sched_state, 6);
    abort_game();
    chk("abort_done_state", sched_state, 0);
    chk("abort_done_positions", positions, 0);
    chk("abort_done_winner", winner_valid, 0);

    // Abort mid-handshake with a coincident colour pulse
    start_game();
    do_turn(2);
    do_turn(3);
    wait_state(2, 64);
    move_ready = 1'b0;
    pulse_roll(1, 2000);
    chk("issue_before_abort", sched_state, 3);
    chk("positions_before_abort", positions, 16'h0032);
    game_abort = 1'b1;
    color_result_ready = 1'b1; movement_steps = 2'd3; color_confidence = 16'd2000;
    @(negedge clk);
    game_abort = 1'b0;
    color_result_ready = 1'b0; movement_steps = 2'd0; color_confidence = 16'd0;
    chk("abort_issue_valid", move_valid, 0);
    chk("abort_issue_state", sched_state, 0);
    chk("abort_issue_positions", positions, 0);
    move_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle_hold", sched_state, 0);

    // Abort and start together in IDLE: remain in IDLE
    game_abort = 1'b1; game_start = 1'b1;
    @(negedge clk);
    game_abort = 1'b0; game_start = 1'b0;
    @(negedge clk);
    chk("abort_start_idle", sched_state, 0);

`ifdef RTS_TURN_TIMEOUT_EN
    // No roll: one skip, turn passes, position untouched
    start_game();
    wait_state(2, 32);
    cyc = 0;
    while (!turn_skipped && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("skip_seen", turn_skipped, 1);
    wait_state(2, 32);
    chk("skip_advanced", active_player, 1);
    chk("skip_positions", positions, 0);
    chk("skip_count", skip_cnt, 1);
    // Roll lands on the timeout cycle: accepted, no skip
    repeat (TMO - 1) @(negedge clk);
    pulse_roll(2, 2000);
    chk("timeout_roll_valid", move_valid, 1);
    repeat (3) @(negedge clk);
    chk("timeout_roll_no_skip", skip_cnt, 1);
    chk("timeout_roll_pos", positions, 16'h0020);
    abort_game();
`else
    // Without the timeout, WAIT_ROLL holds with no skip
    start_game();
    wait_state(2, 32);
    repeat (30) @(negedge clk);
    chk("no_timeout_wait", sched_state, 2);
    chk("no_timeout_skips", skip_cnt, 0);
    abort_game();
`endif
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
